// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg
//   Shared helpers for the dff_pipe delay line and its checker.
//   clog2p1(n)        : bits needed to hold a count in 0..n (occupancy width).
//   DFF_PIPE_STAGE_T  : macro that declares a packed stage record
//                       {vld, data[DW-1:0]} for a given data width, so each
//                       user can build the stage type from its own parameters.
`ifndef DFF_PIPE_PKG_SV
`define DFF_PIPE_PKG_SV

`define DFF_PIPE_STAGE_T(NAME, DW) \
  typedef struct packed { \
    logic            vld; \
    logic [(DW)-1:0] data; \
  } NAME

package dff_pipe_pkg;

  // Width of a counter spanning 0..n inclusive; never narrower than 1 bit.
  function automatic int clog2p1(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

`endif

// File: rtl/dff_pipe_chk.sv
// dff_pipe_chk
//   Bindable checker for dff_pipe. Port names match dff_pipe so it can be
//   attached with '.*'. All checks are inactive while rst_n is low.
//   - out_data/out_valid equal the input seen DEPTH enabled edges earlier,
//     once DEPTH enabled edges have elapsed since the last reset/flush
//     (history kept as a chain of registers gated by en).
//   - a held cycle (!en && !flush) leaves out_data and occupancy unchanged.
//   - a flush empties the pipe on the next edge.
//   - occupancy never exceeds DEPTH.
//   Covers: pipe full; flush while full.
// Ports: identical to dff_pipe, all inputs.
module dff_pipe_chk
  import dff_pipe_pkg::*;
#(
  parameter int            W         = 8,
  parameter int            CH        = 1,
  parameter int            DEPTH     = 2,
  parameter logic [W-1:0]  RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [CH*W-1:0]             in_data,
  input  logic                        out_valid,
  input  logic [CH*W-1:0]             out_data,
  input  logic [clog2p1(DEPTH)-1:0]   occupancy
);

  localparam int CW = clog2p1(DEPTH);
  localparam int DW = CH * W;

  logic [DW-1:0] hist_data_p [DEPTH];
  logic          hist_vld_p  [DEPTH];
  logic [CW-1:0] fill;

  // Number of enabled edges since reset/flush, saturating at DEPTH; the
  // history chain is only meaningful once it is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill <= '0;
    end else if (flush) begin
      fill <= '0;
    end else if (en && (fill != CW'(DEPTH))) begin
      fill <= fill + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (en && !flush) begin
      hist_data_p[0] <= in_data;
      hist_vld_p[0]  <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        hist_data_p[i] <= hist_data_p[i-1];
        hist_vld_p[i]  <= hist_vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && (fill == CW'(DEPTH))) begin
      a_latency: assert ((out_data == hist_data_p[DEPTH-1]) &&
                         (out_valid == hist_vld_p[DEPTH-1]))
        else $error("dff_pipe_chk latency: out=%0h/%0b want %0h/%0b",
                    out_data, out_valid, hist_data_p[DEPTH-1], hist_vld_p[DEPTH-1]);
    end
  end

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (!en && !flush) |=> ($stable(out_data) && $stable(occupancy)))
    else $error("dff_pipe_chk hold: outputs moved while stalled");

  a_flush: assert property (@(posedge clk) disable iff (!rst_n)
    flush |=> (!out_valid && (occupancy == '0) && (out_data == {CH{RESET_VAL}})))
    else $error("dff_pipe_chk flush: pipe not empty after flush");

  a_range: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(occupancy) <= DEPTH))
    else $error("dff_pipe_chk range: occupancy %0d above depth", occupancy);

  c_full: cover property (@(posedge clk) disable iff (!rst_n)
    (int'(occupancy) == DEPTH));

  c_flush_full: cover property (@(posedge clk) disable iff (!rst_n)
    (flush && (int'(occupancy) == DEPTH)));

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe
//   Multi-channel register delay line for retiming / latency balancing.
//   DEPTH stages of {valid, CH*W data}; a beat accepted on an enabled edge
//   reaches the outputs after DEPTH enabled edges. Outputs come straight from
//   the last stage register (no combinational input-to-output path).
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   en         advance all stages; 0 holds everything
//   flush      synchronous clear of all stages and occupancy (beats dropped)
//   in_valid   input beat valid
//   in_data    CH channels, channel c at [c*W +: W]
//   out_valid  valid bit of the last stage
//   out_data   data of the last stage
//   occupancy  number of valid stages, 0..DEPTH
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int            W         = 8,
  parameter int            CH        = 1,
  parameter int            DEPTH     = 2,
  parameter logic [W-1:0]  RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [CH*W-1:0]             in_data,
  output logic                        out_valid,
  output logic [CH*W-1:0]             out_data,
  output logic [clog2p1(DEPTH)-1:0]   occupancy
);

  localparam int              DW       = CH * W;
  localparam int              OCC_W    = clog2p1(DEPTH);
  // Every channel slice gets the same reset/flush value.
  localparam logic [DW-1:0]   RST_DATA = {CH{RESET_VAL}};

  `DFF_PIPE_STAGE_T(stage_t, DW);

  localparam stage_t STAGE_RST = '{vld: 1'b0, data: RST_DATA};

  stage_t in_p0;
  assign in_p0 = '{vld: in_valid, data: in_data};

  // Stage array: s[0] takes the input beat, s[i] takes s[i-1]. Data shifts
  // whether or not the beat is valid, exactly like a plain register chain.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    stage_t d;
    stage_t q;

    if (i == 0) begin : g_head
      assign d = in_p0;
    end else begin : g_tail
      assign d = g_stage[i-1].q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= STAGE_RST;
      end else if (flush) begin
        q <= STAGE_RST;
      end else if (en) begin
        q <= d;
      end
    end
  end

  // Output stage: driven directly from the last stage register.
  logic last_vld;
  assign last_vld  = g_stage[DEPTH-1].q.vld;
  assign out_valid = g_stage[DEPTH-1].q.vld;
  assign out_data  = g_stage[DEPTH-1].q.data;

  // One beat enters and one leaves per enabled edge, so the count only moves
  // when exactly one of them is valid; this keeps it equal to the popcount
  // of the valid bits and inside 0..DEPTH without a saturating adder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (en) begin
      if (in_valid && !last_vld) begin
        occupancy <= occupancy + OCC_W'(1);
      end else if (!in_valid && last_vld) begin
        occupancy <= occupancy - OCC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dff_pipe.sv
bind dff_pipe dff_pipe_chk #(
  .W(W), .CH(CH), .DEPTH(DEPTH), .RESET_VAL(RESET_VAL)
) u_chk (.*);

module tb_dff_pipe;

  logic        clk = 1'b0;
  logic        rst_n;

  // Instance A: W=8, CH=2, DEPTH=3, RESET_VAL=8'h5C
  logic        en, flush, in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  occupancy;

  // Instance B: plain DFF mode, W=1, CH=1, DEPTH=1
  logic        en1, flush1, iv1;
  logic [0:0]  td;
  logic        ov1;
  logic [0:0]  dq;
  logic [0:0]  occ1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dff_pipe #(.W(8), .CH(2), .DEPTH(3), .RESET_VAL(8'h5C)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .occupancy(occupancy)
  );

  dff_pipe #(.W(1), .CH(1), .DEPTH(1), .RESET_VAL(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .flush(flush1),
    .in_valid(iv1), .in_data(td),
    .out_valid(ov1), .out_data(dq), .occupancy(occ1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [15:0] d);
    in_valid = v;
    in_data  = d;
  endtask

  initial begin
    int exp_occ;
    logic exp_v;

    rst_n = 1'b0; en = 1'b0; flush = 1'b0; put(1'b0, 16'h0);
    en1 = 1'b0; flush1 = 1'b0; iv1 = 1'b0; td = 1'b0;
    step(); step();
    chk("rst_oval",  out_valid, 0);
    chk("rst_odata", out_data,  16'h5C5C);
    chk("rst_occ",   occupancy, 0);
    chk("rst_b_oval", ov1, 0);
    chk("rst_b_occ",  occ1, 0);
    rst_n = 1'b1;
    step();

    // T1: single beat, latency DEPTH
    en = 1'b1;
    put(1'b1, 16'hA55A);
    step();
    chk("t1_occ0", occupancy, 1);
    chk("t1_oval0", out_valid, 0);
    put(1'b0, 16'h0);
    step();
    chk("t1_occ1", occupancy, 1);
    chk("t1_oval1", out_valid, 0);
    step();
    chk("t1_oval2", out_valid, 1);
    chk("t1_odata2", out_data, 16'hA55A);
    chk("t1_occ2", occupancy, 1);
    step();
    chk("t1_oval3", out_valid, 0);
    chk("t1_occ3", occupancy, 0);
    chk("t1_odata3", out_data, 16'h0000);

    // T2: beats 1..6 back to back, then drain
    for (int i = 0; i < 9; i++) begin
      put(i < 6, (i < 6) ? 16'(i + 1) : 16'h0);
      step();
      exp_occ = 0;
      for (int j = i - 2; j <= i; j++) if (j >= 0 && j < 6) exp_occ++;
      exp_v = (i >= 2) && (i - 2 < 6);
      chk("t2_occ", occupancy, exp_occ);
      chk("t2_oval", out_valid, exp_v);
      if (exp_v) chk("t2_odata", out_data, i - 1);
    end

    // T3: two beats in, stall 4 cycles, resume
    put(1'b1, 16'h0011); step();
    put(1'b1, 16'h0022); step();
    chk("t3_occ_in", occupancy, 2);
    en = 1'b0;
    put(1'b1, 16'h0033);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_stall_occ", occupancy, 2);
      chk("t3_stall_oval", out_valid, 0);
      chk("t3_stall_odata", out_data, 16'h0000);
    end
    en = 1'b1;
    put(1'b0, 16'h0);
    step();
    chk("t3_res_oval", out_valid, 1);
    chk("t3_res_odata", out_data, 16'h0011);
    chk("t3_res_occ", occupancy, 2);
    step();
    chk("t3_b2_odata", out_data, 16'h0022);
    chk("t3_b2_occ", occupancy, 1);
    step();
    chk("t3_end_oval", out_valid, 0);
    chk("t3_end_occ", occupancy, 0);

    // T4: flush at full occupancy with a valid input beat
    put(1'b1, 16'h0041); step();
    put(1'b1, 16'h0042); step();
    put(1'b1, 16'h0043); step();
    chk("t4_full_occ", occupancy, 3);
    chk("t4_full_odata", out_data, 16'h0041);
    flush = 1'b1;
    put(1'b1, 16'h0099);
    step();
    chk("t4_fl_occ", occupancy, 0);
    chk("t4_fl_oval", out_valid, 0);
    chk("t4_fl_odata", out_data, 16'h5C5C);
    flush = 1'b0;
    put(1'b1, 16'h0077);
    step();
    chk("t4_one_occ", occupancy, 1);
    en = 1'b0; flush = 1'b1;
    put(1'b1, 16'h0088);
    step();
    chk("t4_fl_noen_occ", occupancy, 0);
    chk("t4_fl_noen_odata", out_data, 16'h5C5C);
    en = 1'b1; flush = 1'b0;
    put(1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_drain_oval", out_valid, 0);
      chk("t4_drain_occ", occupancy, 0);
    end

    // T5: async reset between edges with the pipe full
    put(1'b1, 16'h0051); step();
    put(1'b1, 16'h0052); step();
    put(1'b1, 16'h0053); step();
    chk("t5_pre_occ", occupancy, 3);
    chk("t5_pre_oval", out_valid, 1);
    put(1'b1, 16'h0054);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_oval", out_valid, 0);
    chk("t5_async_odata", out_data, 16'h5C5C);
    chk("t5_async_occ", occupancy, 0);
    step();
    chk("t5_held_oval", out_valid, 0);
    chk("t5_held_occ", occupancy, 0);
    rst_n = 1'b1;
    put(1'b1, 16'hBEEF);
    step();
    chk("t5_x0_oval", out_valid, 0);
    chk("t5_x0_odata", out_data, 16'h5C5C);
    chk("t5_x0_occ", occupancy, 1);
    put(1'b0, 16'h0);
    step();
    chk("t5_x1_oval", out_valid, 0);
    chk("t5_x1_odata", out_data, 16'h5C5C);
    step();
    chk("t5_x2_oval", out_valid, 1);
    chk("t5_x2_odata", out_data, 16'hBEEF);
    chk("t5_x2_occ", occupancy, 1);
    step();
    chk("t5_x3_occ", occupancy, 0);

    // T6: DEPTH=1 single flop
    en1 = 1'b1; iv1 = 1'b1;
    td = 1'b0; step();
    chk("t6_d0", dq, 0);
    chk("t6_v0", ov1, 1);
    chk("t6_occ0", occ1, 1);
    td = 1'b1; step();
    chk("t6_d1", dq, 1);
    td = 1'b0; step();
    chk("t6_d2", dq, 0);
    iv1 = 1'b0; td = 1'b1; step();
    chk("t6_inv_d", dq, 1);
    chk("t6_inv_v", ov1, 0);
    chk("t6_inv_occ", occ1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
